reset_seq_multi: RTL and testbench
==================================

RESET_SEQ_MULTI -- requirements
Module: reset_seq_multi

Interface
REQ-001 SHALL have parameter NUM_CH, default 4: number of staged reset channels, 1..16.
REQ-002 SHALL have parameter CNT_W, default 32: width of the internal delay counter.
REQ-003 SHALL have parameter PWRUP_CYC, default 110000: cycles out_nrst_ext is held low after reset.
REQ-004 SHALL have parameter STAGE_CYC, default 16: cycles between successive channel deassertions.
REQ-005 SHALL have parameter SETUP_TMO, default 1000000: cycles allowed for setup_done.
REQ-006 SHALL have port in_clk, input, 1: the single clock.
REQ-007 SHALL have port global_reset_input, input, 1: asynchronous, active-high reset.
REQ-008 SHALL have port rst_semi, input, 1: active-high semi-reset request, synchronous to in_clk.
REQ-009 SHALL have port rst_release, input, 1: active-low level that releases the staged sequence.
REQ-010 SHALL have port setup_done, input, 1: active-high flag indicating the setup block has finished.
REQ-011 SHALL have port out_rst, output, NUM_CH: active-high channel resets; bit 0 is released first.
REQ-012 SHALL have port out_nrst_ext, output, 1: active-low external device reset.
REQ-013 SHALL have port out_nrst_setup, output, 1: active-low reset to the setup block.
REQ-014 SHALL have ports seq_busy and seq_fault, output, 1 each: sequence in progress; setup timeout.

Function
REQ-015 SHALL run an FSM with states PWRUP, SETUP, SETTLE, HOLD, STAGE, RUN and FAULT; all outputs SHALL be registered.
REQ-016 PWRUP: out_rst all 1, out_nrst_ext 0, out_nrst_setup 0; after PWRUP_CYC cycles, go to SETUP with the counter cleared.
REQ-017 SETUP: out_nrst_ext 1, out_nrst_setup 1, out_rst all 1; setup_done=1 -> SETTLE.
REQ-018 SETTLE: hold for exactly 3 cycles, then go to HOLD, or to STAGE if a semi-reset is latched.
REQ-019 HOLD: wait while rst_release=1; rst_release=0 -> STAGE.
REQ-020 STAGE: every STAGE_CYC cycles clear the next out_rst bit in ascending index order; after bit NUM_CH-1 clears, go to RUN.
REQ-021 RUN: out_rst all 0, seq_busy 0; remain in RUN until rst_semi or reset.
REQ-022 rst_semi=1 in SETTLE, HOLD, STAGE or RUN: set out_rst all 1 on the next edge, clear the counter, enter STAGE, and skip HOLD; out_nrst_ext and out_nrst_setup are unaffected.
REQ-023 rst_semi=1 in PWRUP or SETUP: latch it and apply it on exit from SETTLE; the latch clears on entry to STAGE.
REQ-024 If rst_semi coincides with a stage boundary, the semi-reset takes priority and no bit clears.
REQ-025 The counter SHALL saturate rather than wrap; comparisons SHALL be unsigned at CNT_W bits.
REQ-026 seq_busy SHALL be 1 in every state except RUN and FAULT.

Reset
REQ-027 While global_reset_input=1: state PWRUP, counter 0, semi latch 0, out_rst all 1, out_nrst_ext 0, out_nrst_setup 0, seq_busy 1, seq_fault 0.
REQ-028 Reset asserted mid-sequence SHALL take effect immediately and asynchronously; the sequence restarts from PWRUP on the first edge after release.

Configuration
REQ-029 With RSTSEQ_SETUP_TMO_EN defined: SETUP_TMO cycles in SETUP without setup_done -> FAULT, with seq_fault 1, out_rst all 1 and out_nrst_setup 0; only global_reset_input exits FAULT.
REQ-030 Without RSTSEQ_SETUP_TMO_EN: SETUP waits indefinitely, FAULT is unreachable, and seq_fault is tied to 0.

Verification
Bench parameters: NUM_CH=3, PWRUP_CYC=8, STAGE_CYC=4, SETUP_TMO=20.
REQ-031 Release reset, pulse setup_done at cycle 12, drive rst_release=0 at cycle 20 -> out_nrst_ext rises at cycle 8; out_rst goes 111 to 110, 100, 000 at 4-cycle spacing; seq_busy falls with the last bit.
REQ-032 In RUN, pulse rst_semi for 1 cycle -> out_rst=111 on the next cycle, then staged release with no rst_release needed; out_nrst_ext stays 1.
REQ-033 Pulse rst_semi during PWRUP -> after SETTLE, STAGE is entered directly, bypassing HOLD.
REQ-034 Assert rst_semi on the exact cycle bit 1 would clear -> out_rst=111 and the counter restarts.
REQ-035 With the macro defined, hold setup_done=0 -> seq_fault=1 at cycle 8+20, out_nrst_setup=0; without the macro, the FSM stays in SETUP.
REQ-036 Assert global_reset_input in STAGE -> all outputs return to reset values within the same cycle.

Source files
------------

// File: rtl/reset_seq_multi.sv
// Staged reset sequencer: power-up hold, setup handshake, settle, then per-channel release.
// Define RSTSEQ_SETUP_TMO_EN to enable the setup-timeout FAULT state.
module reset_seq_multi #(
    parameter int unsigned NUM_CH    = 4,
    parameter int unsigned CNT_W     = 32,
    parameter int unsigned PWRUP_CYC = 110000,
    parameter int unsigned STAGE_CYC = 16,
    parameter int unsigned SETUP_TMO = 1000000
) (
    input  logic              in_clk,
    input  logic              global_reset_input,
    input  logic              rst_semi,
    input  logic              rst_release,
    input  logic              setup_done,
    output logic [NUM_CH-1:0] out_rst,
    output logic              out_nrst_ext,
    output logic              out_nrst_setup,
    output logic              seq_busy,
    output logic              seq_fault
);

    localparam logic [CNT_W-1:0]  PWRUP_LAST  = CNT_W'(PWRUP_CYC - 1);
    localparam logic [CNT_W-1:0]  STAGE_LAST  = CNT_W'(STAGE_CYC - 1);
    localparam logic [CNT_W-1:0]  SETTLE_LAST = CNT_W'(2);
    localparam logic [NUM_CH-1:0] RST_LAST    = NUM_CH'(1) << (NUM_CH - 1);
`ifdef RSTSEQ_SETUP_TMO_EN
    localparam logic [CNT_W-1:0]  TMO_LAST    = CNT_W'(SETUP_TMO - 1);
`endif

    if (NUM_CH < 1 || NUM_CH > 16 || PWRUP_CYC < 1 || STAGE_CYC < 1 || SETUP_TMO < 1)
    begin : g_param_err
        $error("reset_seq_multi: parameter out of range");
    end

    typedef enum logic [2:0] {
        S_PWRUP,
        S_SETUP,
        S_SETTLE,
        S_HOLD,
        S_STAGE,
        S_RUN,
        S_FAULT
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_sat_inc;
    logic             semi_lat;

    assign cnt_sat_inc = (cnt == '1) ? cnt : cnt + CNT_W'(1);

    // A semi-reset seen before SETTLE is remembered until the sequence reaches STAGE.
    always_ff @(posedge in_clk or posedge global_reset_input) begin
        if (global_reset_input) begin
            state          <= S_PWRUP;
            cnt            <= '0;
            semi_lat       <= 1'b0;
            out_rst        <= '1;
            out_nrst_ext   <= 1'b0;
            out_nrst_setup <= 1'b0;
            seq_busy       <= 1'b1;
`ifdef RSTSEQ_SETUP_TMO_EN
            seq_fault      <= 1'b0;
`endif
        end else if (rst_semi && (state == S_SETTLE || state == S_HOLD ||
                                  state == S_STAGE  || state == S_RUN)) begin
            state    <= S_STAGE;
            cnt      <= '0;
            semi_lat <= 1'b0;
            out_rst  <= '1;
            seq_busy <= 1'b1;
        end else begin
            case (state)
                S_PWRUP: begin
                    if (rst_semi) semi_lat <= 1'b1;
                    if (cnt == PWRUP_LAST) begin
                        state          <= S_SETUP;
                        cnt            <= '0;
                        out_nrst_ext   <= 1'b1;
                        out_nrst_setup <= 1'b1;
                    end else begin
                        cnt <= cnt_sat_inc;
                    end
                end
                S_SETUP: begin
                    if (rst_semi) semi_lat <= 1'b1;
                    if (setup_done) begin
                        state <= S_SETTLE;
                        cnt   <= '0;
                    end
`ifdef RSTSEQ_SETUP_TMO_EN
                    else if (cnt == TMO_LAST) begin
                        state          <= S_FAULT;
                        out_nrst_setup <= 1'b0;
                        seq_busy       <= 1'b0;
                        seq_fault      <= 1'b1;
                    end
`endif
                    else begin
                        cnt <= cnt_sat_inc;
                    end
                end
                S_SETTLE: begin
                    if (cnt == SETTLE_LAST) begin
                        cnt      <= '0;
                        semi_lat <= 1'b0;
                        state    <= semi_lat ? S_STAGE : S_HOLD;
                    end else begin
                        cnt <= cnt_sat_inc;
                    end
                end
                S_HOLD: begin
                    if (!rst_release) begin
                        state    <= S_STAGE;
                        cnt      <= '0;
                        semi_lat <= 1'b0;
                    end
                end
                // Channels release lowest index first by shifting zeros in from bit 0.
                S_STAGE: begin
                    if (cnt == STAGE_LAST) begin
                        cnt     <= '0;
                        out_rst <= out_rst << 1;
                        if (out_rst == RST_LAST) begin
                            state    <= S_RUN;
                            seq_busy <= 1'b0;
                        end
                    end else begin
                        cnt <= cnt_sat_inc;
                    end
                end
                S_RUN: begin
                end
                S_FAULT: begin
                end
                default: begin
                    state <= S_PWRUP;
                    cnt   <= '0;
                end
            endcase
        end
    end

`ifndef RSTSEQ_SETUP_TMO_EN
    assign seq_fault = 1'b0;
`endif

endmodule

// File: tb/tb_reset_seq_multi.sv
// Scoreboard bench for reset_seq_multi: expected output-change events come from an
// edge-timestamp model of the sequence; a negedge monitor pops and compares on every output change.
module tb_reset_seq_multi;

    localparam int NC   = 3;
    localparam int P    = 8;
    localparam int SC   = 4;
    localparam int TMO  = 20;
    localparam int MAXE = 80;

    localparam logic [NC-1:0] ALL       = '1;
    localparam logic [6:0]    RESET_VEC = {ALL, 1'b0, 1'b0, 1'b1, 1'b0};

    typedef struct {
        int         edge_no;
        logic [6:0] v;
    } ev_t;

    logic          in_clk;
    logic          global_reset_input;
    logic          rst_semi;
    logic          rst_release;
    logic          setup_done;
    logic [NC-1:0] out_rst;
    logic          out_nrst_ext;
    logic          out_nrst_setup;
    logic          seq_busy;
    logic          seq_fault;
    logic [6:0]    dut_vec;

    int   checks = 0;
    int   errors = 0;
    int   tb_edge;
    ev_t  sb_q[$];
    logic sd_a[MAXE+1];
    logic rel_a[MAXE+1];
    logic semi_a[MAXE+1];
    logic [6:0] mon_prev;

    reset_seq_multi #(
        .NUM_CH(NC), .CNT_W(16), .PWRUP_CYC(P), .STAGE_CYC(SC), .SETUP_TMO(TMO)
    ) dut (
        .in_clk(in_clk),
        .global_reset_input(global_reset_input),
        .rst_semi(rst_semi),
        .rst_release(rst_release),
        .setup_done(setup_done),
        .out_rst(out_rst),
        .out_nrst_ext(out_nrst_ext),
        .out_nrst_setup(out_nrst_setup),
        .seq_busy(seq_busy),
        .seq_fault(seq_fault)
    );

    assign dut_vec = {out_rst, out_nrst_ext, out_nrst_setup, seq_busy, seq_fault};

    initial in_clk = 1'b0;
    always #5 in_clk = ~in_clk;

    // Edge 1 is the first rising edge after reset release.
    always @(posedge in_clk or posedge global_reset_input) begin
        if (global_reset_input) tb_edge <= 0;
        else                    tb_edge <= tb_edge + 1;
    end

    // Monitor: every output change must match the next queued expectation, value and edge.
    always @(negedge in_clk) begin
        ev_t ev;
        if (global_reset_input) begin
            mon_prev = RESET_VEC;
        end else if (dut_vec != mon_prev) begin
            checks++;
            if (sb_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_change edge=%0d got=%b", tb_edge, dut_vec);
            end else begin
                ev = sb_q.pop_front();
                if (ev.v != dut_vec || ev.edge_no != tb_edge) begin
                    errors++;
                    $display("FAIL output_change got=%b@edge%0d expected=%b@edge%0d",
                             dut_vec, tb_edge, ev.v, ev.edge_no);
                end
            end
            mon_prev = dut_vec;
        end
    end

    function automatic logic [6:0] pack(input logic [NC-1:0] r, input logic ext,
                                        input logic stp, input logic busy, input logic flt);
        return {r, ext, stp, busy, flt};
    endfunction

    // Reference: derive the setup-done edge, the stage-start edge and restarts from input timestamps.
    task automatic build_expect(input int n);
        logic [6:0]    exp_v;
        logic [6:0]    prev_v;
        logic [NC-1:0] r;
        int d, s, k, fault_e;
        bit latched;
        d = -1;
        for (int e = P + 1; e <= n; e++) if (sd_a[e] && d < 0) d = e;
        fault_e = -1;
`ifdef RSTSEQ_SETUP_TMO_EN
        if (d < 0 || d > P + TMO) begin
            d = -1;
            fault_e = P + TMO;
        end
`endif
        latched = 1'b0;
        if (d > 0) for (int e = 1; e <= d; e++) if (semi_a[e]) latched = 1'b1;
        s = -1;
        if (d > 0) begin
            for (int e = d + 1; e <= d + 3 && e <= n; e++) if (semi_a[e] && s < 0) s = e;
            if (s < 0 && latched && d + 3 <= n) s = d + 3;
            if (s < 0)
                for (int e = d + 4; e <= n; e++) if ((semi_a[e] || !rel_a[e]) && s < 0) s = e;
        end
        prev_v = RESET_VEC;
        for (int e = 1; e <= n; e++) begin
            if (e < P) begin
                exp_v = RESET_VEC;
            end else if (fault_e > 0 && e >= fault_e) begin
                exp_v = pack(ALL, 1'b1, 1'b0, 1'b0, 1'b1);
            end else if (s < 0 || e < s) begin
                exp_v = pack(ALL, 1'b1, 1'b1, 1'b1, 1'b0);
            end else begin
                if (e > s && semi_a[e]) s = e;
                k = (e - s) / SC;
                r = ALL << k;
                exp_v = pack(r, 1'b1, 1'b1, (k < NC), 1'b0);
            end
            if (exp_v != prev_v) sb_q.push_back('{e, exp_v});
            prev_v = exp_v;
        end
    endtask

    task automatic check_vec(input string name, input logic [6:0] exp_v);
        checks++;
        if (dut_vec !== exp_v) begin
            errors++;
            $display("FAIL %s got=%b expected=%b", name, dut_vec, exp_v);
        end
    endtask

    task automatic clear_stim();
        for (int e = 0; e <= MAXE; e++) begin
            sd_a[e]   = 1'b0;
            rel_a[e]  = 1'b1;
            semi_a[e] = 1'b0;
        end
    endtask

    // rst_at > 0 asserts the async reset a few ns after that edge, between clock edges.
    task automatic run_scn(input int n, input int rst_at);
        global_reset_input = 1'b1;
        rst_semi    = 1'b0;
        rst_release = 1'b1;
        setup_done  = 1'b0;
        repeat (2) @(negedge in_clk);
        check_vec("reset_hold", RESET_VEC);
        sb_q.delete();
        build_expect((rst_at > 0) ? rst_at : n);
        global_reset_input = 1'b0;
        for (int e = 1; e <= n; e++) begin
            setup_done  = sd_a[e];
            rst_release = rel_a[e];
            rst_semi    = semi_a[e];
            @(posedge in_clk);
            if (e == rst_at) begin
                #2 global_reset_input = 1'b1;
                #1 check_vec("async_reset", RESET_VEC);
                break;
            end
            @(negedge in_clk);
        end
        #1;
        checks++;
        if (sb_q.size() != 0) begin
            errors++;
            $display("FAIL missing_change pending=%0d next_expected=%b@edge%0d",
                     sb_q.size(), sb_q[0].v, sb_q[0].edge_no);
        end
        sb_q.delete();
    endtask

    initial begin
        int sd_start, sd_len, rel_start;
        global_reset_input = 1'b1;
        rst_semi    = 1'b0;
        rst_release = 1'b1;
        setup_done  = 1'b0;

        // Basic sequence: setup_done at 12, release low from 20.
        clear_stim();
        sd_a[12] = 1'b1;
        for (int e = 20; e <= MAXE; e++) rel_a[e] = 1'b0;
        run_scn(40, 0);

        // Semi-reset in RUN restages without rst_release.
        clear_stim();
        sd_a[12] = 1'b1;
        for (int e = 20; e <= 30; e++) rel_a[e] = 1'b0;
        semi_a[36] = 1'b1;
        run_scn(55, 0);

        // Semi-reset during PWRUP bypasses HOLD.
        clear_stim();
        sd_a[12] = 1'b1;
        semi_a[3] = 1'b1;
        run_scn(35, 0);

        // Semi-reset on the bit-1 boundary wins.
        clear_stim();
        sd_a[12] = 1'b1;
        for (int e = 20; e <= MAXE; e++) rel_a[e] = 1'b0;
        semi_a[28] = 1'b1;
        run_scn(50, 0);

        // No setup_done: timeout fault, or indefinite SETUP.
        clear_stim();
        run_scn(40, 0);

        // Async reset mid-STAGE, then a clean restart.
        clear_stim();
        sd_a[12] = 1'b1;
        for (int e = 20; e <= MAXE; e++) rel_a[e] = 1'b0;
        run_scn(40, 26);

        for (int t = 0; t < 14; t++) begin
            clear_stim();
            sd_start  = int'($urandom_range(35, 4));
            sd_len    = int'($urandom_range(3, 1));
            rel_start = int'($urandom_range(60, 10));
            for (int e = sd_start; e < sd_start + sd_len; e++) sd_a[e] = 1'b1;
            for (int e = rel_start; e <= MAXE; e++) rel_a[e] = 1'b0;
            for (int e = 1; e <= MAXE; e++) semi_a[e] = ($urandom_range(24, 0) == 0);
            run_scn(70, (t % 5 == 4) ? int'($urandom_range(60, 10)) : 0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
